// File: rtl/elevator_car_if.sv
// Controller <-> car plant link: motor/door commands one way, floor sensors and car status the other.
// The controller side is the master; the car model is the slave.
interface elevator_car_if;
  logic       up;
  logic       down;
  logic       stop;
  logic       open_door;
  logic       S1;
  logic       S2;
  logic       S3;
  logic       S4;
  logic [1:0] floor;
  logic       moving;
  logic       door_open;
  logic       door_closed;
  logic       fault;

  modport master (
    output up, down, stop, open_door,
    input  S1, S2, S3, S4, floor, moving, door_open, door_closed, fault
  );

  modport slave (
    input  up, down, stop, open_door,
    output S1, S2, S3, S4, floor, moving, door_open, door_closed, fault
  );
endinterface

// File: rtl/elevator_car_model.sv
// Plant model of a 4-floor elevator car and door driven by up/down/stop/open_door commands.
// Outputs are functions of registered state only (one edge of latency); there is no backpressure, illegal commands latch a sticky fault.
module elevator_car_model #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int LEVEL_CYCLES  = 3,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic           clk,
  input  logic           reset,
  elevator_car_if.slave  car
);

  localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);
  localparam logic [3:0] LEVEL_LAST  = 4'(LEVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LAST   = 8'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    PARKED,
    MOVE_UP,
    MOVE_DN,
    OPENING,
    OPEN,
    CLOSING,
    FAULT
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] floor_q, floor_nxt;
  logic [7:0] pos_cnt, pos_nxt;
  logic [3:0] dwell_cnt, dwell_nxt;
  logic [7:0] door_cnt, door_nxt;
  logic       door_open_q, door_open_nxt;
  logic       door_closed_q, door_closed_nxt;

  logic cmd_ok;
  logic door_req;
  logic same_dir;
  logic opp_dir;
  logic at_end;

  // Exactly one of the three motor commands: odd count but not all three.
  assign cmd_ok   = (car.up ^ car.down ^ car.stop) & ~(car.up & car.down & car.stop);
  assign door_req = car.stop & car.open_door;
  assign same_dir = (state == MOVE_UP) ? car.up   : car.down;
  assign opp_dir  = (state == MOVE_UP) ? car.down : car.up;
  assign at_end   = (state == MOVE_UP) ? (floor_q == 2'd3) : (floor_q == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= PARKED;
      floor_q       <= 2'd0;
      pos_cnt       <= 8'd0;
      dwell_cnt     <= 4'd0;
      door_cnt      <= 8'd0;
      door_open_q   <= 1'b0;
      door_closed_q <= 1'b1;
    end else begin
      state         <= state_nxt;
      floor_q       <= floor_nxt;
      pos_cnt       <= pos_nxt;
      dwell_cnt     <= dwell_nxt;
      door_cnt      <= door_nxt;
      door_open_q   <= door_open_nxt;
      door_closed_q <= door_closed_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    floor_nxt       = floor_q;
    pos_nxt         = pos_cnt;
    dwell_nxt       = dwell_cnt;
    door_nxt        = door_cnt;
    door_open_nxt   = door_open_q;
    door_closed_nxt = door_closed_q;

    case (state)
      PARKED: begin
        if (car.up) begin
          if (floor_q == 2'd3) begin
            state_nxt = FAULT;
          end else begin
            state_nxt = MOVE_UP;
            pos_nxt   = 8'd1;
          end
        end else if (car.down) begin
          if (floor_q == 2'd0) begin
            state_nxt = FAULT;
          end else begin
            state_nxt = MOVE_DN;
            pos_nxt   = 8'd1;
          end
        end else if (door_req) begin
          state_nxt = OPENING;
          door_nxt  = 8'd0;
        end
      end

      MOVE_UP, MOVE_DN: begin
        if (pos_cnt != 8'd0) begin
          if (!same_dir) begin
            state_nxt = FAULT;
          end else if (pos_cnt == TRAVEL_LAST) begin
            pos_nxt   = 8'd0;
            dwell_nxt = 4'd0;
            floor_nxt = (state == MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
          end else begin
            pos_nxt = pos_cnt + 8'd1;
          end
        end else if (car.stop) begin
          state_nxt = PARKED;
        end else if (opp_dir) begin
          state_nxt = FAULT;
        end else if (dwell_cnt == LEVEL_LAST) begin
          // Dwell expired with the run still commanded: leave, unless this is the end of the shaft.
          if (at_end) begin
            state_nxt = FAULT;
          end else begin
            pos_nxt = 8'd1;
          end
        end else begin
          dwell_nxt = dwell_cnt + 4'd1;
        end
      end

      OPENING: begin
        if (door_cnt == DOOR_LAST) begin
          state_nxt = OPEN;
        end else begin
          door_nxt = door_cnt + 8'd1;
        end
      end

      OPEN: begin
        if (!door_req) begin
          state_nxt = CLOSING;
          door_nxt  = 8'd0;
        end
      end

      CLOSING: begin
        if (door_req) begin
          state_nxt = OPENING;
          door_nxt  = 8'd0;
        end else if (door_cnt == DOOR_LAST) begin
          state_nxt = PARKED;
        end else begin
          door_nxt = door_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = FAULT;
      end
    endcase

    // An illegal command freezes the car where it is, overriding any move above.
    if (state != FAULT && !cmd_ok) begin
      state_nxt = FAULT;
      floor_nxt = floor_q;
      pos_nxt   = pos_cnt;
      dwell_nxt = dwell_cnt;
      door_nxt  = door_cnt;
    end

    if (state_nxt != FAULT) begin
      door_open_nxt   = (state_nxt == OPEN);
      door_closed_nxt = (state_nxt == PARKED) || (state_nxt == MOVE_UP) || (state_nxt == MOVE_DN);
    end
  end

  assign car.S1          = (pos_cnt == 8'd0) && (floor_q == 2'd0);
  assign car.S2          = (pos_cnt == 8'd0) && (floor_q == 2'd1);
  assign car.S3          = (pos_cnt == 8'd0) && (floor_q == 2'd2);
  assign car.S4          = (pos_cnt == 8'd0) && (floor_q == 2'd3);
  assign car.floor       = floor_q;
  assign car.moving      = (state == MOVE_UP) || (state == MOVE_DN);
  assign car.door_open   = door_open_q;
  assign car.door_closed = door_closed_q;
  assign car.fault       = (state == FAULT);

endmodule

// File: tb/tb_elevator_car_model.sv
// Bench for elevator_car_model: fixed vector table, hand-written corner sequences, then random commands against a position/timer model.
module tb_elevator_car_model;

  localparam int T = 8;
  localparam int L = 3;
  localparam int D = 4;

  logic clk;
  logic reset;
  elevator_car_if bus();

  elevator_car_model #(
    .TRAVEL_CYCLES (T),
    .LEVEL_CYCLES  (L),
    .DOOR_CYCLES   (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .car   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute car position in travel ticks (floor*T + offset) plus door stroke timer.
  int m_p, m_dir, m_ldir, m_dwell, m_stroke, m_dt;
  bit m_open, m_fault;

  function automatic void model_reset();
    m_p = 0; m_dir = 0; m_ldir = 0; m_dwell = 0;
    m_stroke = 0; m_dt = 0; m_open = 0; m_fault = 0;
  endfunction

  function automatic void model_step(bit u, bit d, bit s, bit o);
    int  n;
    bit  same, opp, level;
    if (m_fault) return;
    n = int'(u) + int'(d) + int'(s);
    if (n != 1) begin
      m_fault = 1;
      return;
    end
    level = (m_p % T) == 0;
    if (m_dir != 0) begin
      same = (m_dir > 0) ? u : d;
      opp  = (m_dir > 0) ? d : u;
      if (!level) begin
        if (same) begin
          m_p += m_dir;
          m_dwell = 0;
        end else m_fault = 1;
      end else if (s) m_dir = 0;
      else if (opp) m_fault = 1;
      else if (m_dwell == L - 1) begin
        if ((m_dir > 0 && m_p == 3 * T) || (m_dir < 0 && m_p == 0)) m_fault = 1;
        else m_p += m_dir;
      end else m_dwell++;
    end else if (m_stroke == 0 && !m_open) begin
      if (u) begin
        if (m_p == 3 * T) m_fault = 1;
        else begin m_dir = 1; m_ldir = 1; m_p += 1; end
      end else if (d) begin
        if (m_p == 0) m_fault = 1;
        else begin m_dir = -1; m_ldir = -1; m_p -= 1; end
      end else if (o) begin
        m_stroke = 1; m_dt = 0;
      end
    end else if (m_stroke > 0) begin
      m_dt++;
      if (m_dt == D) begin m_stroke = 0; m_open = 1; end
    end else if (m_open) begin
      if (!(s && o)) begin m_open = 0; m_stroke = -1; m_dt = 0; end
    end else begin
      if (s && o) begin m_stroke = 1; m_dt = 0; end
      else begin
        m_dt++;
        if (m_dt == D) m_stroke = 0;
      end
    end
  endfunction

  // Packed as {S4,S3,S2,S1, floor[1:0], moving, door_open, door_closed, fault}.
  function automatic logic [9:0] model_vec();
    logic [3:0] s;
    int         fl;
    bit         level;
    level = (m_p % T) == 0;
    fl = (!level && m_ldir < 0) ? m_p / T + 1 : m_p / T;
    s = 4'b0000;
    if (level) s[m_p / T] = 1'b1;
    return {s, 2'(fl), (m_dir != 0) && !m_fault, m_open, (m_stroke == 0) && !m_open, m_fault};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {bus.S4, bus.S3, bus.S2, bus.S1, bus.floor, bus.moving,
            bus.door_open, bus.door_closed, bus.fault};
  endfunction

  task automatic check_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got S4..S1/floor/mov/open/closed/fault=%b required %b", name, $time, act, exp);
    end
  endtask

  task automatic tick(input bit u, input bit d, input bit s, input bit o);
    bus.up = u; bus.down = d; bus.stop = s; bus.open_door = o;
    @(posedge clk);
    model_step(u, d, s, o);
    #1;
    check_vec("model", dut_vec(), model_vec());
  endtask

  localparam logic [9:0] RESET_VEC = 10'b0001_00_0_0_1_0;

  // Asynchronous reset asserted between edges; outputs must settle before the next edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_vec("reset", dut_vec(), RESET_VEC);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit         u, d, s, o;
    int         rep;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit u, bit d, bit s, bit o, int rep, logic [9:0] exp);
    vec_t v;
    v.u = u; v.d = d; v.s = s; v.o = o; v.rep = rep; v.exp = exp;
    return v;
  endfunction

  initial begin
    localparam logic [9:0] MID_F0  = 10'b0000_00_1_0_1_0;
    localparam logic [9:0] AT_F1   = 10'b0010_01_1_0_1_0;
    localparam logic [9:0] PARK_F1 = 10'b0010_01_0_0_1_0;
    localparam logic [9:0] DOOR_MV = 10'b0010_01_0_0_0_0;
    localparam logic [9:0] OPEN_F1 = 10'b0010_01_0_1_0_0;
    localparam logic [9:0] MID_F1  = 10'b0000_01_1_0_1_0;
    localparam logic [9:0] AT_F2   = 10'b0100_10_1_0_1_0;
    localparam logic [9:0] MID_F2  = 10'b0000_10_1_0_1_0;
    localparam logic [9:0] AT_F3   = 10'b1000_11_1_0_1_0;
    localparam logic [9:0] FLT_F3  = 10'b1000_11_0_0_1_1;

    vecs.push_back(mk(1,0,0,0, 7, MID_F0));
    vecs.push_back(mk(1,0,0,0, 2, AT_F1));
    vecs.push_back(mk(0,0,1,0, 1, PARK_F1));
    vecs.push_back(mk(0,0,1,1, 4, DOOR_MV));
    vecs.push_back(mk(0,0,1,1, 1, OPEN_F1));
    vecs.push_back(mk(0,0,1,0, 2, DOOR_MV));
    vecs.push_back(mk(0,0,1,1, 4, DOOR_MV));
    vecs.push_back(mk(0,0,1,1, 1, OPEN_F1));
    vecs.push_back(mk(0,0,1,0, 4, DOOR_MV));
    vecs.push_back(mk(0,0,1,0, 1, PARK_F1));
    vecs.push_back(mk(1,0,0,0, 7, MID_F1));
    vecs.push_back(mk(1,0,0,0, 3, AT_F2));
    vecs.push_back(mk(1,0,0,0, 7, MID_F2));
    vecs.push_back(mk(1,0,0,0, 3, AT_F3));
    vecs.push_back(mk(1,0,0,0, 1, FLT_F3));
    vecs.push_back(mk(1,1,0,0, 2, FLT_F3));
    vecs.push_back(mk(0,0,1,1, 2, FLT_F3));

    reset = 1'b0;
    bus.up = 1'b0; bus.down = 1'b0; bus.stop = 1'b1; bus.open_door = 1'b0;
    @(negedge clk);
    do_reset();

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        tick(vecs[i].u, vecs[i].d, vecs[i].s, vecs[i].o);
        check_vec("table", dut_vec(), vecs[i].exp);
      end
    end

    // Two motor commands at once while parked.
    do_reset();
    tick(1, 1, 0, 0);
    check_vec("illegal_updown", dut_vec(), 10'b0001_00_0_0_1_1);
    tick(0, 0, 1, 0);
    check_vec("fault_sticky", dut_vec(), 10'b0001_00_0_0_1_1);

    // Stop between floors at pos_cnt=4.
    do_reset();
    for (int k = 0; k < 4; k++) tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    check_vec("stop_midtravel", dut_vec(), 10'b0000_00_0_0_1_1);

    // Down from floor 0 is an overrun.
    do_reset();
    tick(0, 1, 0, 0);
    check_vec("down_at_f0", dut_vec(), 10'b0001_00_0_0_1_1);

    // Reset between floor1 and floor2, then a normal departure.
    do_reset();
    for (int k = 0; k < T; k++) tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) tick(1, 0, 0, 0);
    check_vec("midtravel_f1", dut_vec(), MID_F1);
    do_reset();
    tick(1, 0, 0, 0);
    check_vec("depart_after_reset", dut_vec(), MID_F0);

    // Random command runs.
    do_reset();
    for (int ph = 0; ph < 400; ph++) begin
      int sel, hold;
      bit u, d, s, o;
      if (m_fault && $urandom_range(0, 1) == 1) do_reset();
      sel  = $urandom_range(0, 39);
      hold = $urandom_range(1, 10);
      o    = $urandom_range(0, 1) == 1;
      if (sel == 0) begin
        {u, d, s} = 3'($urandom_range(0, 7));
        if (u + d + s == 1) {u, d, s} = 3'b111;
        hold = 1;
      end else if (sel < 13) begin
        {u, d, s} = 3'b100;
      end else if (sel < 25) begin
        {u, d, s} = 3'b010;
      end else if (sel < 31) begin
        {u, d, s} = 3'b001;
      end else begin
        {u, d, s} = 3'b001;
        o = 1'b1;
      end
      for (int k = 0; k < hold; k++) tick(u, d, s, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
